// File: rtl/conv11_pkg.sv
// Shared definitions for the 1x1-conv MAC datapath: state encoding, default widths
// and saturation bounds used by the requantiser.
package conv11_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MAC   = 3'd2,
    ST_POST  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  function automatic longint sat_max(input int dw);
    return (longint'(1) << (dw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/conv11_requant.sv
// Combinational requantiser: bias add, round-half-up arithmetic shift, optional ReLU
// and saturation to the signed result width.
module conv11_requant
  import conv11_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int SHIFT      = 7,
  parameter int RELU_EN    = 1
) (
  input  logic [ACC_WIDTH-1:0]  i_acc,
  input  logic [ACC_WIDTH-1:0]  i_bias,
  output logic [DATA_WIDTH-1:0] o_result
);

  // Two guard bits so the bias add and rounding offset can never wrap.
  localparam int TW = ACC_WIDTH + 2;
  localparam logic [TW-1:0] RND = (TW'(1) << SHIFT) >> 1;

  logic signed [TW-1:0] w_sum;
  logic signed [TW-1:0] w_rnd;
  logic signed [TW-1:0] w_relu;
  logic signed [63:0]   w_wide;

  always_comb begin
    w_sum  = TW'($signed(i_acc)) + TW'($signed(i_bias));
    w_rnd  = (w_sum + $signed(RND)) >>> SHIFT;
    w_relu = ((RELU_EN != 0) && w_rnd[TW-1]) ? '0 : w_rnd;
    w_wide = 64'(w_relu);
    if (w_wide > sat_max(DATA_WIDTH)) begin
      o_result = DATA_WIDTH'(sat_max(DATA_WIDTH));
    end else if (w_wide < sat_min(DATA_WIDTH)) begin
      o_result = DATA_WIDTH'(sat_min(DATA_WIDTH));
    end else begin
      o_result = w_wide[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/conv11_mac_unit.sv
// 1x1-conv MAC: pulls one activation per input channel from the input buffer,
// accumulates act*weight over IN_CH channels, then requantises and offers the result.
module conv11_mac_unit
  import conv11_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  IN_CH      = 16,
  parameter int  ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int  SHIFT      = 7,
  parameter int  RELU_EN    = 1,
  localparam int AW         = (IN_CH > 1) ? $clog2(IN_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_inputbuf_load,
  input  logic [DATA_WIDTH-1:0] i_act_in,
  output logic                  o_inputbuf_read_en,
  output logic [AW-1:0]         o_weight_addr,
  input  logic [DATA_WIDTH-1:0] i_weight_in,
  input  logic [ACC_WIDTH-1:0]  i_bias_in,
  output logic [DATA_WIDTH-1:0] o_result_data,
  output logic                  o_result_valid,
  input  logic                  i_result_ready,
  output logic                  o_busy
);

  localparam int            PW   = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(IN_CH - 1);

  state_t                r_state, w_state_nxt;
  logic [ACC_WIDTH-1:0]  r_acc, w_acc_nxt;
  logic [AW-1:0]         r_ch_cnt, w_ch_nxt;
  logic                  r_read_en, w_read_en_nxt;
  logic                  r_result_valid, w_valid_nxt;
  logic [DATA_WIDTH-1:0] r_result_data, w_data_nxt;

  logic signed [DATA_WIDTH-1:0] w_act_s;
  logic signed [DATA_WIDTH-1:0] w_wt_s;
  logic signed [PW-1:0]         w_prod;
  logic [DATA_WIDTH-1:0]        w_requant;

  assign w_act_s = i_act_in;
  assign w_wt_s  = i_weight_in;
  assign w_prod  = PW'(w_act_s) * PW'(w_wt_s);

  conv11_requant #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SHIFT      (SHIFT),
    .RELU_EN    (RELU_EN)
  ) u_requant (
    .i_acc    (r_acc),
    .i_bias   (i_bias_in),
    .o_result (w_requant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_acc          <= '0;
      r_ch_cnt       <= '0;
      r_read_en      <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_acc          <= w_acc_nxt;
      r_ch_cnt       <= w_ch_nxt;
      r_read_en      <= w_read_en_nxt;
      r_result_valid <= w_valid_nxt;
      r_result_data  <= w_data_nxt;
    end
  end

  // The buffer's registered output lands in MAC, one cycle after the FETCH strobe.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_ch_nxt      = r_ch_cnt;
    w_read_en_nxt = 1'b0;
    w_valid_nxt   = r_result_valid;
    w_data_nxt    = r_result_data;
    case (r_state)
      ST_IDLE: begin
        if (i_inputbuf_load) begin
          w_read_en_nxt = 1'b1;
          w_state_nxt   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_state_nxt = ST_MAC;
      end
      ST_MAC: begin
        w_acc_nxt = r_acc + ACC_WIDTH'(w_prod);
        if (r_ch_cnt == LAST) begin
          w_state_nxt = ST_POST;
        end else begin
          w_ch_nxt    = r_ch_cnt + AW'(1);
          w_state_nxt = ST_IDLE;
        end
      end
      ST_POST: begin
        w_data_nxt  = w_requant;
        w_valid_nxt = 1'b1;
        w_acc_nxt   = '0;
        w_ch_nxt    = '0;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (i_result_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_inputbuf_read_en = r_read_en;
  assign o_weight_addr      = r_ch_cnt;
  assign o_result_data      = r_result_data;
  assign o_result_valid     = r_result_valid;
  assign o_busy             = (r_state != ST_IDLE) || (r_ch_cnt != '0);

endmodule

// File: tb/tb_conv11_mac_unit.sv
// Scoreboard bench for conv11_mac_unit: two instances (ReLU on/off) share a buffer and
// weight-memory model; expected results come from a plain-arithmetic reference.
`timescale 1ns/1ps
module tb_conv11_mac_unit;

  localparam int DW    = 8;
  localparam int IN_CH = 4;
  localparam int ACC_W = 32;
  localparam int SHIFT = 2;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic          ready = 1'b0;
  logic [ACC_W-1:0] bias = '0;
  logic [DW-1:0] act_in = '0, act_nr = '0;
  logic [DW-1:0] wt, wt_nr;
  logic          rd, rd_nr, vld, vld_nr, busy, busy_nr;
  logic [AW-1:0] waddr, waddr_nr;
  logic [DW-1:0] res, res_nr;

  int act_arr[IN_CH];
  int wt_arr[IN_CH];
  int exp_q[$];
  int exp_nr_q[$];
  int errors = 0;
  int checks = 0;
  bit load_steady = 1'b0;

  always #5 clk = ~clk;

  conv11_mac_unit #(.DATA_WIDTH(DW), .IN_CH(IN_CH), .ACC_WIDTH(ACC_W), .SHIFT(SHIFT), .RELU_EN(1)) u_dut (
    .clk(clk), .rst(rst), .i_inputbuf_load(load), .i_act_in(act_in), .o_inputbuf_read_en(rd),
    .o_weight_addr(waddr), .i_weight_in(wt), .i_bias_in(bias), .o_result_data(res),
    .o_result_valid(vld), .i_result_ready(ready), .o_busy(busy));

  conv11_mac_unit #(.DATA_WIDTH(DW), .IN_CH(IN_CH), .ACC_WIDTH(ACC_W), .SHIFT(SHIFT), .RELU_EN(0)) u_dut_nr (
    .clk(clk), .rst(rst), .i_inputbuf_load(load), .i_act_in(act_nr), .o_inputbuf_read_en(rd_nr),
    .o_weight_addr(waddr_nr), .i_weight_in(wt_nr), .i_bias_in(bias), .o_result_data(res_nr),
    .o_result_valid(vld_nr), .i_result_ready(ready), .o_busy(busy_nr));

  // Weight memory is combinational; the input buffer registers its output on read strobe.
  assign wt    = DW'(wt_arr[waddr]);
  assign wt_nr = DW'(wt_arr[waddr_nr]);
  always @(posedge clk) begin
    if (rd)    act_in <= DW'(act_arr[waddr]);
    if (rd_nr) act_nr <= DW'(act_arr[waddr_nr]);
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int s8(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int ref_result(input int a[IN_CH], input int w[IN_CH], input int b, input bit relu);
    longint t, d, q;
    t = b;
    for (int i = 0; i < IN_CH; i++) t += longint'(a[i]) * longint'(w[i]);
    d = longint'(1) << SHIFT;
    if (SHIFT > 0) begin
      t = t + d / 2;
      q = t / d;
      if ((t % d) != 0 && t < 0) q = q - 1;
      t = q;
    end
    if (relu && t < 0) t = 0;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return int'(t);
  endfunction

  // Monitor: handshake timing, read-strobe rules and scoreboard pops.
  int  cyc = 0, last_rd = -1, hs_cyc = -1, rd_cnt = 0, exp_ch = 0;
  logic prev_rd = 1'b0, prev_vld = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_rd = -1; hs_cyc = -1; rd_cnt = 0; exp_ch = 0; prev_rd = 1'b0; prev_vld = 1'b0;
    end else begin
      if (!load_steady) hs_cyc = -1;
      if (rd) begin
        check("rd_not_consecutive", int'(prev_rd), 0);
        check("rd_not_in_hold", int'(vld), 0);
        check("rd_addr", int'(waddr), exp_ch);
        check("rd_lockstep_norelu", int'(rd_nr), 1);
        if (last_rd >= 0) check("rd_spacing", cyc - last_rd, 3);
        if (hs_cyc >= 0) check("rd_after_handshake", cyc - hs_cyc, 2);
        last_rd = cyc; hs_cyc = -1; rd_cnt++; exp_ch++;
      end
      if (vld && !prev_vld) check("valid_latency", cyc - last_rd, 3);
      if (vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else if (ready) begin
          check("result", s8(res), exp_q.pop_front());
        end else begin
          check("hold_stable", s8(res), exp_q[0]);
        end
      end
      if (vld_nr && ready) begin
        if (exp_nr_q.size() == 0) check("unexpected_result_norelu", 1, 0);
        else check("result_norelu", s8(res_nr), exp_nr_q.pop_front());
      end
      if (vld && ready) begin
        check("rd_count", rd_cnt, IN_CH);
        hs_cyc = cyc; last_rd = -1; rd_cnt = 0; exp_ch = 0;
      end
      prev_rd = rd; prev_vld = vld;
    end
  end

  task automatic run_pixel(input int a[IN_CH], input int w[IN_CH], input int b,
                           input int bp, input int gap, output bit ok);
    int n;
    ok = 1'b1;
    act_arr = a;
    wt_arr  = w;
    bias    = ACC_W'(b);
    exp_q.push_back(ref_result(a, w, b, 1'b1));
    exp_nr_q.push_back(ref_result(a, w, b, 1'b0));
    load = 1'b1;
    load_steady = 1'b1;
    n = 0;
    while (!vld && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!vld) begin
      check("result_valid_timeout", 0, 1);
      ok = 1'b0;
      return;
    end
    repeat (bp) begin
      @(posedge clk); #1;
    end
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    if (gap > 0) begin
      load_steady = 1'b0;
      load = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
      check("busy_idle", int'(busy), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read_en"}, int'({rd, rd_nr}), 0);
    check({tag, "_weight_addr"}, int'({waddr, waddr_nr}), 0);
    check({tag, "_valid"}, int'({vld, vld_nr}), 0);
    check({tag, "_data"}, int'({res, res_nr}), 0);
    check({tag, "_busy"}, int'({busy, busy_nr}), 0);
  endtask

  initial begin
    int  a_basic[IN_CH], w_basic[IN_CH], a[IN_CH], w[IN_CH];
    bit  ok;
    int  n;
    a_basic = '{1, 2, 3, 4};
    w_basic = '{1, -1, 2, 3};
    act_arr = '{0, 0, 0, 0};
    wt_arr  = '{0, 0, 0, 0};
    ok = 1'b1;

    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("idle_no_read", int'(rd), 0);

    run_pixel(a_basic, w_basic, 3, 0, 0, ok);
    if (ok) begin
      a = '{10, 10, 10, 10}; w = '{-10, -10, -10, -10};
      run_pixel(a, w, 0, 0, 1, ok);
    end
    if (ok) begin
      a = '{127, 127, 127, 127}; w = '{127, 127, 127, 127};
      run_pixel(a, w, 0, 0, 0, ok);
    end
    if (ok) run_pixel(a_basic, w_basic, 3, 5, 0, ok);
    for (int p = 0; p < 2 && ok; p++) begin
      for (int i = 0; i < IN_CH; i++) begin
        a[i] = int'($urandom_range(255)) - 128;
        w[i] = int'($urandom_range(255)) - 128;
      end
      run_pixel(a, w, int'($urandom_range(2000)) - 1000, 0, 0, ok);
    end

    if (ok) begin
      act_arr = '{9, 9, 9, 9};
      wt_arr  = '{7, 7, 7, 7};
      bias    = ACC_W'(100);
      load = 1'b1;
      load_steady = 1'b1;
      n = 0;
      while (waddr != 2'd2 && n < 100) begin
        @(posedge clk); #1; n++;
      end
      check("partial_progress", int'(waddr), 2);
      rst = 1'b1;
      #1;
      check_reset_outputs("midreset");
      repeat (2) begin
        @(posedge clk); #1;
      end
      check_reset_outputs("midreset_hold");
      rst = 1'b0;
      run_pixel(a_basic, w_basic, 3, 0, 0, ok);
    end

    for (int p = 0; p < 8 && ok; p++) begin
      for (int i = 0; i < IN_CH; i++) begin
        if (p % 2 == 0) begin
          a[i] = int'($urandom_range(255)) - 128;
          w[i] = int'($urandom_range(255)) - 128;
        end else begin
          a[i] = int'($urandom_range(15)) - 8;
          w[i] = int'($urandom_range(15)) - 8;
        end
      end
      run_pixel(a, w, int'($urandom_range(600)) - 300,
                int'($urandom_range(3)), int'($urandom_range(2)), ok);
    end

    repeat (4) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("scoreboard_drained_norelu", exp_nr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv11_mac_unit.md
Name: conv11_mac_unit

Overview:
- Downstream consumer of the 1x1-conv input buffer.
- Handshakes one activation per input channel out of the buffer and fetches the matching signed weight from weight memory by address.
- Accumulates over IN_CH channels, adds bias, rounds/shifts, applies optional ReLU and saturates.
- Presents one output-channel pixel result on a valid/ready interface to the next stage (output buffer / pooling).

Parameters:
- DATA_WIDTH, 8, activation, weight and result width (signed two's complement).
- IN_CH, 16, input channels accumulated per result (>=1).
- ACC_WIDTH, 32, accumulator and bias width.
- SHIFT, 7, requantisation right-shift (0 = none).
- RELU_EN, 1, 1 = clamp negative results to 0.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous, active-high reset.
- inputbuf_load, in, 1, buffer holds an unread activation.
- act_in, in, DATA_WIDTH, buffer registered output; valid the cycle after inputbuf_read_en.
- inputbuf_read_en, out, 1, one-cycle read strobe to buffer.
- weight_addr, out, max(1,$clog2(IN_CH)), current channel index to weight memory.
- weight_in, in, DATA_WIDTH, weight for weight_addr; combinational or stable ≥1 cycle.
- bias_in, in, ACC_WIDTH, signed bias, sampled in POST.
- result_data, out, DATA_WIDTH, requantised result.
- result_valid, out, 1, result available.
- result_ready, in, 1, downstream accepts result.
- busy, out, 1, high whenever state != IDLE or ch_cnt != 0.

Behaviour:
- Reset (async): state=IDLE, acc=0, ch_cnt=0, weight_addr=0, inputbuf_read_en=0, result_valid=0, result_data=0, busy=0. Any partial sum is discarded; the next pixel restarts at channel 0.
- FSM states: IDLE, FETCH, MAC, POST, HOLD.
- IDLE: if inputbuf_load=1, register inputbuf_read_en<=1 and go to FETCH; else stay.
- FETCH: read_en is high this cycle (exactly one cycle); clear read_en; go to MAC. weight_addr=ch_cnt is held from IDLE onward.
- MAC: act_in and weight_in are valid. acc <= acc + sext(act_in*weight_in), with a signed 2*DATA_WIDTH product.
  - If ch_cnt==IN_CH-1: go to POST.
  - Else: ch_cnt++, weight_addr++, go to IDLE.
- POST:
  - t = acc + bias_in.
  - If SHIFT>0: t = (t + (1<<(SHIFT-1))) >>> SHIFT (arithmetic shift, round half up).
  - If RELU_EN and t<0: t=0.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
  - result_data<=t, result_valid<=1, acc<=0, ch_cnt<=0, weight_addr<=0; go to HOLD.
- HOLD: result_valid and result_data are stable while result_ready=0.
  - When result_valid&&result_ready at an edge: result_valid<=0; go to IDLE.
  - No read_en is issued in HOLD (backpressure reaches the buffer via inputbuf_load staying high).
- Throughput: 3 cycles per channel minimum (IDLE→FETCH→MAC). result_valid rises 1 cycle after the last MAC, i.e. ≥3*IN_CH+1 cycles from the first load seen.
- inputbuf_load held continuously high gives read_en exactly every 3rd cycle, never two consecutive cycles.
- inputbuf_load toggling while in FETCH/MAC/POST/HOLD is ignored until IDLE.
- IN_CH=1: MAC goes directly to POST every pixel.
- Accumulator wrap is not checked; ACC_WIDTH must be ≥2*DW+$clog2(IN_CH).

Decomposition:
- Shared package conv11_pkg:
  - FSM state encoding (localparams).
  - Default DATA_WIDTH/ACC_WIDTH.
  - Saturation bounds function.
- Natural sub-module: conv11_requant (combinational bias-add, round-shift, ReLU, saturate), reused by other conv stages.
- The FSM and accumulator stay in conv11_mac_unit.

Test Plan:
- Basic, IN_CH=4, SHIFT=2, RELU_EN=1:
  - Stimulus: acts 1,2,3,4; weights 1,-1,2,3; bias 3.
  - Response: sum 17, t=20, result_data=5, result_valid on cycle after 4th MAC; exactly 4 read_en pulses at addr 0..3.
- ReLU and saturation, same config:
  - Stimulus A: acts 10×4, weights -10, bias 0 → result 0.
  - Stimulus B: acts 127×4, weights 127 → 64516>>2=16129 → result 127.
  - Stimulus C: with RELU_EN=0, case A → -100.
- Backpressure:
  - Stimulus: result_ready=0 for 5 cycles after result_valid, buffer keeps load=1.
  - Response: valid/data stable, no read_en during HOLD; read_en resumes 2 cycles after the handshake edge.
- Back-to-back:
  - Stimulus: inputbuf_load tied high, 2 pixels.
  - Response: read_en spaced exactly 3 cycles apart; second result independent of the first (acc cleared).
- Reset mid-pixel:
  - Stimulus: assert rst after 2 of 4 MACs, then a full pixel with the basic vector.
  - Response: all outputs 0 during reset; result_data=5 afterwards, no residue.
